// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: display modes and
// the active-low gfedcba hex glyph table.
package seg7_pkg;

  localparam logic [1:0] MODE_FULL   = 2'b00;
  localparam logic [1:0] MODE_LO     = 2'b01;
  localparam logic [1:0] MODE_HI     = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit hex display driver with capture/shadow anti-tear
// buffering, per-slot blanking guard, half-word modes and leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int GUARD       = 4,
  parameter int LZB         = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic [1:0]  sw,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic [7:0]  upd_count
);

  logic [15:0] prescaler_r;
  logic [2:0]  idx_r;
  logic [31:0] hold_r;
  logic [31:0] shadow_r;

  logic        terminal_s;
  logic        wrap_s;
  logic        accept_s;
  logic        guard_s;
  logic        half_mode_s;
  logic        out_of_range_s;
  logic        lz_s;
  logic [31:0] disp_word_s;
  logic [31:0] upper_s;
  logic [3:0]  nibble_s;
  logic [6:0]  hex_seg_s;
  logic [7:0]  an_next_s;
  logic [6:0]  seg_next_s;
  logic        dp_next_s;

  assign terminal_s = (prescaler_r == 16'(REFRESH_DIV - 1));
  assign wrap_s     = terminal_s && (idx_r == 3'd7);
  assign accept_s   = data_valid && (sw != MODE_FREEZE);
  assign guard_s    = ({16'd0, prescaler_r} < 32'(GUARD));

  // Scan timing, capture register, frame-aligned shadow copy and capture count
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_r <= 16'd0;
      idx_r       <= 3'd0;
      hold_r      <= 32'd0;
      shadow_r    <= 32'd0;
      upd_count   <= 8'd0;
    end else begin
      prescaler_r <= terminal_s ? 16'd0 : prescaler_r + 16'd1;
      if (terminal_s) idx_r <= idx_r + 3'd1;
      if (accept_s) begin
        hold_r    <= data_in;
        upd_count <= upd_count + 8'd1;
      end
      // Shadow takes the pre-edge hold value, so a coincident capture waits a frame
      if (wrap_s) shadow_r <= hold_r;
    end
  end

  // Select which 32-bit word the eight digit slots present in the current mode
  always_comb begin
    disp_word_s = shadow_r;
    case (sw)
      MODE_LO: disp_word_s = {16'd0, shadow_r[15:0]};
      MODE_HI: disp_word_s = {16'd0, shadow_r[31:16]};
      default: disp_word_s = shadow_r;
    endcase
  end

  assign upper_s        = disp_word_s >> {idx_r, 2'b00};
  assign nibble_s       = upper_s[3:0];
  assign half_mode_s    = (sw == MODE_LO) || (sw == MODE_HI);
  assign out_of_range_s = half_mode_s && idx_r[2];
  // Digit and everything above it zero means a leading zero; slot 0 always shows
  assign lz_s           = (LZB != 0) && (idx_r != 3'd0) && (upper_s == 32'd0);

  hex_to_seg7 u_hex (
    .nibble (nibble_s),
    .seg    (hex_seg_s)
  );

  // Next-state values for the anode, cathode and decimal-point registers
  always_comb begin
    an_next_s  = 8'hFF;
    seg_next_s = SEG_BLANK;
    dp_next_s  = 1'b1;
    if (guard_s) begin
      an_next_s  = 8'hFF;
      seg_next_s = SEG_BLANK;
      dp_next_s  = 1'b1;
    end else begin
      an_next_s = ~(8'd1 << idx_r);
      if (out_of_range_s || lz_s) begin
        seg_next_s = SEG_BLANK;
      end else begin
        seg_next_s = hex_seg_s;
      end
      dp_next_s = !((idx_r == 3'd4) && !half_mode_s);
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_next_s;
      seg <= seg_next_s;
      dp  <= dp_next_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with a short refresh period: a vector table
// plus hand-written sequences for freeze, wrap-coincident capture and reset.
module tb_seg7_scan;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_valid;
  logic [31:0] data_in;
  logic [1:0]  sw;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [7:0]  an0, an1, upd0, upd1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg7_scan #(.REFRESH_DIV(RD), .GUARD(GD), .LZB(0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .sw(sw),
    .seg(seg0), .dp(dp0), .an(an0), .upd_count(upd0)
  );

  seg7_scan #(.REFRESH_DIV(RD), .GUARD(GD), .LZB(1)) dut_lzb (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .sw(sw),
    .seg(seg1), .dp(dp1), .an(an1), .upd_count(upd1)
  );

  typedef struct {
    bit          cap;
    logic [31:0] data;
    logic [1:0]  mode;
    bit          lzb;
    int          idx;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  typedef struct {
    bit         lzb;
    int         idx;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit cap, input logic [31:0] d, input logic [1:0] m,
                         input bit lzb, input int idx, input logic [6:0] s, input logic p);
    vec_t v;
    v.cap = cap; v.data = d; v.mode = m; v.lzb = lzb; v.idx = idx; v.seg = s; v.dp = p;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input bit lzb, input int idx, input logic [6:0] s,
                          input logic p, input string name);
    exp_t e;
    e.lzb = lzb; e.idx = idx; e.seg = s; e.dp = p; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic capture(input logic [31:0] d);
    @(negedge clk);
    data_in    = d;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Wait (bounded) for the chosen DUT to light digit idx, then compare seg/dp
  task automatic drain();
    exp_t       e;
    bit         ok;
    logic [7:0] want, cur;
    while (sb_q.size() > 0) begin
      e    = sb_q.pop_front();
      want = ~(8'd1 << e.idx);
      ok   = 1'b0;
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        cur = e.lzb ? an1 : an0;
        if (cur == want) begin
          ok = 1'b1;
          break;
        end
      end
      check($sformatf("%s idx%0d digit-appears", e.name, e.idx), 32'(ok), 32'd1);
      if (ok) begin
        check($sformatf("%s idx%0d seg", e.name, e.idx), 32'(e.lzb ? seg1 : seg0), 32'(e.seg));
        check($sformatf("%s idx%0d dp", e.name, e.idx), 32'(e.lzb ? dp1 : dp0), 32'(e.dp));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard_cnt, bad_cnt, blank_bad;
    bit ok;

    reset = 1'b1; data_valid = 1'b0; data_in = 32'd0; sw = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset an",        32'(an0),  32'hFF);
    check("reset seg",       32'(seg0), 32'h7F);
    check("reset dp",        32'(dp0),  32'd1);
    check("reset upd_count", 32'(upd0), 32'd0);
    check("reset an lzb",    32'(an1),  32'hFF);
    reset = 1'b0;

    // Idle frame: 2 guard clocks per slot, otherwise exactly one anode low
    repeat (4) @(negedge clk);
    guard_cnt = 0; bad_cnt = 0; blank_bad = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (an0 == 8'hFF) begin
        guard_cnt++;
        if (seg0 != 7'h7F) blank_bad++;
      end else begin
        if ($countones(~an0) != 1) bad_cnt++;
        if (seg0 != 7'h40) blank_bad++;
      end
    end
    check("idle guard clocks",      32'(guard_cnt), 32'(8 * GD));
    check("idle one-hot anodes",    32'(bad_cnt),   32'd0);
    check("idle seg values",        32'(blank_bad), 32'd0);
    check("idle upd_count",         32'(upd0),      32'd0);

    add_vec(0, 32'h0,        2'b00, 0, 0, 7'h40, 1'b1);
    add_vec(0, 32'h0,        2'b00, 0, 4, 7'h40, 1'b0);
    add_vec(0, 32'h0,        2'b00, 0, 7, 7'h40, 1'b1);
    add_vec(1, 32'h1234ABCD, 2'b00, 0, 0, 7'h21, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 1, 7'h46, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 2, 7'h03, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 3, 7'h08, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 4, 7'h19, 1'b0);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 5, 7'h30, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 6, 7'h24, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 0, 7, 7'h79, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b00, 1, 7, 7'h79, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b01, 0, 0, 7'h21, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b01, 0, 3, 7'h08, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b01, 0, 4, 7'h7F, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b01, 0, 7, 7'h7F, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b10, 0, 0, 7'h19, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b10, 0, 1, 7'h30, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b10, 0, 2, 7'h24, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b10, 0, 3, 7'h79, 1'b1);
    add_vec(0, 32'h1234ABCD, 2'b10, 0, 5, 7'h7F, 1'b1);
    add_vec(1, 32'h00000A00, 2'b00, 1, 0, 7'h40, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 1, 1, 7'h40, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 1, 2, 7'h08, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 1, 3, 7'h7F, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 1, 4, 7'h7F, 1'b0);
    add_vec(0, 32'h00000A00, 2'b00, 1, 7, 7'h7F, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 0, 7, 7'h40, 1'b1);
    add_vec(0, 32'h00000A00, 2'b00, 0, 3, 7'h40, 1'b1);

    foreach (vecs[i]) begin
      sw = vecs[i].mode;
      if (vecs[i].cap) begin
        capture(vecs[i].data);
        repeat (2 * FRAME) @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
      end
      push_exp(vecs[i].lzb, vecs[i].idx, vecs[i].seg, vecs[i].dp, $sformatf("vec%0d", i));
      drain();
    end
    check("upd_count after table",     32'(upd0), 32'd2);
    check("upd_count after table lzb", 32'(upd1), 32'd2);

    // Freeze ignores captures; leaving freeze lets a new one through
    sw = 2'b11;
    capture(32'hFFFFFFFF);
    repeat (2 * FRAME) @(negedge clk);
    check("freeze upd_count", 32'(upd0), 32'd2);
    push_exp(0, 0, 7'h40, 1'b1, "freeze");
    push_exp(0, 2, 7'h08, 1'b1, "freeze");
    push_exp(0, 4, 7'h40, 1'b0, "freeze");
    drain();
    sw = 2'b00;
    capture(32'h00000005);
    check("unfreeze upd_count", 32'(upd0), 32'd3);
    repeat (2 * FRAME) @(negedge clk);
    push_exp(0, 0, 7'h12, 1'b1, "unfreeze");
    push_exp(0, 2, 7'h40, 1'b1, "unfreeze");
    drain();

    // Capture on the exact idx 7->0 wrap edge: old word shows for one more frame
    ok = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (an0 == 8'hBF) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int c = 0; c < 2 * FRAME; c++) begin
        @(negedge clk);
        if (an0 == 8'h7F) begin ok = 1'b1; break; end
      end
    end
    check("wrap locate digit7", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    data_in    = 32'h00000007;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    push_exp(0, 0, 7'h12, 1'b1, "wrap old frame");
    drain();
    repeat (FRAME) @(negedge clk);
    push_exp(0, 0, 7'h78, 1'b1, "wrap next frame");
    drain();
    check("wrap upd_count", 32'(upd0), 32'd4);

    // Mid-frame reset with a coincident capture that must be discarded
    push_exp(0, 3, 7'h40, 1'b1, "pre-reset");
    drain();
    reset      = 1'b1;
    data_valid = 1'b1;
    data_in    = 32'hAAAAAAAA;
    @(negedge clk);
    check("midreset an",        32'(an0),  32'hFF);
    check("midreset seg",       32'(seg0), 32'h7F);
    check("midreset dp",        32'(dp0),  32'd1);
    check("midreset upd_count", 32'(upd0), 32'd0);
    check("midreset upd lzb",   32'(upd1), 32'd0);
    reset      = 1'b0;
    data_valid = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    push_exp(0, 0, 7'h40, 1'b1, "post-reset");
    push_exp(0, 4, 7'h40, 1'b0, "post-reset");
    push_exp(1, 1, 7'h7F, 1'b1, "post-reset");
    drain();
    check("post-reset upd_count", 32'(upd0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
